proc_imm_gen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the processor datapath. Accepts an instruction word and immediate-type selector on a val/rdy input channel. Decodes the sign/zero-extended immediate at XLEN width, adding CSR-zimm and shift-amount types and explicit illegal-type flagging. Results are buffered in a DEPTH-entry FIFO and presented on a val/rdy output channel, so the block sits between the decode stage and the X stage without stalling decode on transient X backpressure.

---
 rtl/proc_imm_pkg.sv | 30 +++
 rtl/proc_imm_gen_pipe_if.sv | 38 +++
 rtl/proc_imm_decode.sv | 64 ++++++
 rtl/proc_imm_gen_pipe.sv | 104 ++++++++++
 tb/tb_proc_imm_gen_pipe.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/proc_imm_pkg.sv
// -----------------------------------------------------------------------------
// proc_imm_pkg
// Shared types and constants for the pipelined immediate generator.
//   imm_type_e    : 4-bit immediate-type selector, including illegal encodings
//   ILLEGAL_CNT_W : width of the saturating illegal-type counter
// -----------------------------------------------------------------------------
package proc_imm_pkg;

  localparam int ILLEGAL_CNT_W = 16;

  typedef enum logic [3:0] {
    IMM_I     = 4'd0,
    IMM_S     = 4'd1,
    IMM_B     = 4'd2,
    IMM_U     = 4'd3,
    IMM_J     = 4'd4,
    IMM_Z     = 4'd5,   // CSR zimm
    IMM_SH    = 4'd6,   // shift amount
    IMM_ILL7  = 4'd7,
    IMM_CI    = 4'd8,
    IMM_CIW   = 4'd9,
    IMM_CJ    = 4'd10,
    IMM_CB    = 4'd11,
    IMM_ILL12 = 4'd12,
    IMM_ILL13 = 4'd13,
    IMM_ILL14 = 4'd14,
    IMM_ILL15 = 4'd15
  } imm_type_e;

endpackage

// File: rtl/proc_imm_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// proc_imm_gen_pipe_if
// Input and output val/rdy channels of the immediate generator.
//   in_val/in_rdy/in_inst/in_type/in_tag          : decode-side request
//   out_val/out_rdy/out_imm/out_tag/out_illegal   : X-stage result
//   illegal_cnt                                   : saturating illegal count
// Modports: master = producer/consumer side, slave = the generator.
// -----------------------------------------------------------------------------
interface proc_imm_gen_pipe_if
  import proc_imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TAGW = 4
) ();

  logic                     in_val;
  logic                     in_rdy;
  logic [31:0]              in_inst;
  logic [3:0]               in_type;
  logic [TAGW-1:0]          in_tag;
  logic                     out_val;
  logic                     out_rdy;
  logic [XLEN-1:0]          out_imm;
  logic [TAGW-1:0]          out_tag;
  logic                     out_illegal;
  logic [ILLEGAL_CNT_W-1:0] illegal_cnt;

  modport master (
    output in_val, in_inst, in_type, in_tag, out_rdy,
    input  in_rdy, out_val, out_imm, out_tag, out_illegal, illegal_cnt
  );

  modport slave (
    input  in_val, in_inst, in_type, in_tag, out_rdy,
    output in_rdy, out_val, out_imm, out_tag, out_illegal, illegal_cnt
  );

endinterface

// File: rtl/proc_imm_decode.sv
// -----------------------------------------------------------------------------
// proc_imm_decode
// Purely combinational immediate decoder.
//   inst_i    : instruction word (RVC types use inst_i[15:0])
//   type_i    : immediate type selector
//   imm_o     : sign/zero-extended immediate, XLEN bits
//   illegal_o : type_i is not a supported encoding (imm_o forced to 0)
// Compressed types 8-11 decode only when PROC_IMM_GEN_RVC_EN is defined;
// otherwise they are illegal.
// -----------------------------------------------------------------------------
module proc_imm_decode
  import proc_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  input  imm_type_e       type_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  // Everything is built at 64 bits; sign extension to 64 then truncation to
  // XLEN is identical to extending straight to XLEN.
  logic [63:0] wide;
  logic        unused_bits;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a latch behind.
    wide      = '0;
    illegal_o = 1'b0;
    unique case (type_i)
      IMM_I:  wide = {{52{inst_i[31]}}, inst_i[31:20]};
      IMM_S:  wide = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:  wide = {{51{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                      inst_i[11:8], 1'b0};
      IMM_U:  wide = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};
      IMM_J:  wide = {{43{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                      inst_i[30:21], 1'b0};
      IMM_Z:  wide = {59'b0, inst_i[19:15]};
      // RV64 shift amounts carry one extra bit.
      IMM_SH: wide = (XLEN == 64) ? {58'b0, inst_i[25:20]}
                                  : {59'b0, inst_i[24:20]};
`ifdef PROC_IMM_GEN_RVC_EN
      IMM_CI:  wide = {{58{inst_i[12]}}, inst_i[12], inst_i[6:2]};
      IMM_CIW: wide = {54'b0, inst_i[10:7], inst_i[12:11], inst_i[5],
                       inst_i[6], 2'b0};
      IMM_CJ:  wide = {{52{inst_i[12]}}, inst_i[12], inst_i[8], inst_i[10:9],
                       inst_i[6], inst_i[7], inst_i[2], inst_i[11],
                       inst_i[5:3], 1'b0};
      IMM_CB:  wide = {{55{inst_i[12]}}, inst_i[12], inst_i[6:5], inst_i[2],
                       inst_i[11:10], inst_i[4:3], 1'b0};
`endif
      default: illegal_o = 1'b1;
    endcase
  end

  assign imm_o = wide[XLEN-1:0];

  // Some instruction bits and (for XLEN=32) the upper half of wide are
  // intentionally not needed by any type.
  assign unused_bits = ^{inst_i, wide};

endmodule

// File: rtl/proc_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// proc_imm_gen_pipe
// Pipelined immediate generator: decodes an immediate on input fire and
// buffers it, with the request tag and an illegal flag, in a DEPTH-entry FIFO
// read out on a val/rdy channel. in_rdy depends on state only.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset; discards all entries
//   bus     : proc_imm_gen_pipe_if.slave (input channel, output channel,
//             illegal_cnt)
// Parameters: XLEN (32/64), DEPTH (power of two, >= 2), TAGW.
// Build option: define PROC_IMM_GEN_RVC_EN to decode compressed types 8-11.
// -----------------------------------------------------------------------------
module proc_imm_gen_pipe
  import proc_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAGW  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  proc_imm_gen_pipe_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [TAGW-1:0] tag;
    logic            illegal;
  } entry_t;

  entry_t                   mem_q [DEPTH];
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q, count_d;
  logic [ILLEGAL_CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic            in_fire, out_fire;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  proc_imm_decode #(.XLEN(XLEN)) u_decode (
    .inst_i    (bus.in_inst),
    .type_i    (imm_type_e'(bus.in_type)),
    .imm_o     (dec_imm),
    .illegal_o (dec_illegal)
  );

  assign bus.in_rdy  = (count_q != CW'(DEPTH));
  assign bus.out_val = (count_q != '0);
  assign in_fire     = bus.in_val && bus.in_rdy;
  assign out_fire    = bus.out_val && bus.out_rdy;

  // Head entry drives the outputs directly, so they hold while stalled.
  assign bus.out_imm     = mem_q[rd_ptr_q].imm;
  assign bus.out_tag     = mem_q[rd_ptr_q].tag;
  assign bus.out_illegal = mem_q[rd_ptr_q].illegal;
  assign bus.illegal_cnt = illegal_cnt_q;

  always_comb begin
    count_d = count_q;
    unique case ({in_fire, out_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (in_fire && dec_illegal && (illegal_cnt_q != '1)) begin
      illegal_cnt_d = illegal_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      illegal_cnt_q <= '0;
    end else begin
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (in_fire)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (out_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage is reset because out_imm/out_tag/out_illegal must read 0
  // after reset; a storage array without reset would power up undefined.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (in_fire) begin
      mem_q[wr_ptr_q] <= '{imm: dec_imm, tag: bus.in_tag, illegal: dec_illegal};
    end
  end

endmodule

// File: tb/tb_proc_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_proc_imm_gen_pipe
// Directed bench: an XLEN=32 instance carries most vectors and the FIFO,
// saturation, streaming and reset scenarios; an XLEN=64 instance checks the
// wide sign extension and RV64 shift amount. Expected compressed-type results
// follow PROC_IMM_GEN_RVC_EN.
// -----------------------------------------------------------------------------
module tb_proc_imm_gen_pipe;
  import proc_imm_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] exp_cnt = '0;
  logic [3:0]  tag_ctr = '0;

  always #5 clk = ~clk;

  proc_imm_gen_pipe_if #(.XLEN(32), .TAGW(4)) b ();
  proc_imm_gen_pipe_if #(.XLEN(64), .TAGW(4)) b64 ();

  proc_imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAGW(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b)
  );

  proc_imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAGW(4)) dut64 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b64)
  );

  task automatic check(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the 32-bit instance: one-cycle latency, head contents,
  // illegal count, then drain.
  task automatic one(input string name, input logic [3:0] t,
                     input logic [31:0] inst, input logic [31:0] exp_imm,
                     input logic exp_ill);
    tag_ctr   = tag_ctr + 4'd1;
    b.in_val  = 1'b1;
    b.in_type = t;
    b.in_inst = inst;
    b.in_tag  = tag_ctr;
    tick();
    b.in_val = 1'b0;
    if (exp_ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    check({name, ".val"}, 64'(b.out_val), 64'd1);
    check({name, ".imm"}, 64'(b.out_imm), 64'(exp_imm));
    check({name, ".ill"}, 64'(b.out_illegal), 64'(exp_ill));
    check({name, ".tag"}, 64'(b.out_tag), 64'(tag_ctr));
    check({name, ".cnt"}, 64'(b.illegal_cnt), 64'(exp_cnt));
    b.out_rdy = 1'b1;
    tick();
    b.out_rdy = 1'b0;
    check({name, ".drain"}, 64'(b.out_val), 64'd0);
  endtask

  task automatic one64(input string name, input logic [3:0] t,
                       input logic [31:0] inst, input logic [63:0] exp_imm);
    b64.in_val  = 1'b1;
    b64.in_type = t;
    b64.in_inst = inst;
    b64.in_tag  = 4'd9;
    tick();
    b64.in_val = 1'b0;
    check({name, ".val"}, 64'(b64.out_val), 64'd1);
    check({name, ".imm"}, b64.out_imm, exp_imm);
    b64.out_rdy = 1'b1;
    tick();
    b64.out_rdy = 1'b0;
  endtask

  initial begin
    b.in_val = 1'b0;   b.in_type = '0;   b.in_inst = '0;   b.in_tag = '0;
    b.out_rdy = 1'b0;
    b64.in_val = 1'b0; b64.in_type = '0; b64.in_inst = '0; b64.in_tag = '0;
    b64.out_rdy = 1'b0;
    reset_n = 1'b1;

    // Reset takes effect before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    check("rst.out_val", 64'(b.out_val), 64'd0);
    check("rst.in_rdy", 64'(b.in_rdy), 64'd1);
    check("rst.illegal_cnt", 64'(b.illegal_cnt), 64'd0);
    check("rst.out_imm", 64'(b.out_imm), 64'd0);
    check("rst.out_tag", 64'(b.out_tag), 64'd0);
    check("rst.out_illegal", 64'(b.out_illegal), 64'd0);
    check("rst.out_imm64", b64.out_imm, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Base immediate types, XLEN=32.
    one("i_neg",   IMM_I,  32'hFFF00093, 32'hFFFF_FFFF, 1'b0);
    one("s_sign",  IMM_S,  32'h8000_0000, 32'hFFFF_F800, 1'b0);
    one("s_low",   IMM_S,  32'h0000_0F80, 32'h0000_001F, 1'b0);
    one("b_sign",  IMM_B,  32'h8000_0000, 32'hFFFF_F000, 1'b0);
    one("b_bit11", IMM_B,  32'h0000_0080, 32'h0000_0800, 1'b0);
    one("u_neg",   IMM_U,  32'h800000B7, 32'h8000_0000, 1'b0);
    one("j_sign",  IMM_J,  32'h8000_0000, 32'hFFF0_0000, 1'b0);
    one("j_bit11", IMM_J,  32'h0010_0000, 32'h0000_0800, 1'b0);
    one("z_max",   IMM_Z,  32'h000F_8000, 32'h0000_001F, 1'b0);
    one("sh_31",   IMM_SH, 32'h01F0D093, 32'h0000_001F, 1'b0);
    one("sh_b25",  IMM_SH, 32'h0200_0000, 32'h0000_0000, 1'b0);
    one("ill7",    IMM_ILL7,  32'h0000_0000, 32'h0, 1'b1);
    one("ill12",   IMM_ILL12, 32'hFFFF_FFFF, 32'h0, 1'b1);
`ifdef PROC_IMM_GEN_RVC_EN
    one("cj_m2",   IMM_CJ, 32'h0000_BFFD, 32'hFFFF_FFFE, 1'b0);
    one("ci_neg",  IMM_CI, 32'h0000_1000, 32'hFFFF_FFE0, 1'b0);
`else
    one("cj_ill",  IMM_CJ, 32'h0000_BFFD, 32'h0, 1'b1);
    one("ci_ill",  IMM_CI, 32'h0000_1000, 32'h0, 1'b1);
`endif

    // XLEN=64 extension and RV64 shift amount.
    one64("x64_i",  IMM_I,  32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF);
    one64("x64_u",  IMM_U,  32'h800000B7, 64'hFFFF_FFFF_8000_0000);
    one64("x64_sh", IMM_SH, 32'h0200_0000, 64'h0000_0000_0000_0020);

    // Fill a 2-deep FIFO while stalled, then drain in order.
    b.in_type = IMM_I; b.in_inst = 32'h0;
    b.in_val = 1'b1; b.in_tag = 4'd1;
    tick();
    b.in_tag = 4'd2;
    check("full.rdy_after1", 64'(b.in_rdy), 64'd1);
    tick();
    b.in_tag = 4'd3;
    check("full.rdy_after2", 64'(b.in_rdy), 64'd0);
    tick();
    check("full.rdy_held", 64'(b.in_rdy), 64'd0);
    check("full.head_stable", 64'(b.out_tag), 64'd1);
    b.out_rdy = 1'b1;
    tick();
    check("full.rdy_back", 64'(b.in_rdy), 64'd1);
    check("full.tag2", 64'(b.out_tag), 64'd2);
    tick();
    b.in_val = 1'b0;
    check("full.simul_val", 64'(b.out_val), 64'd1);
    check("full.tag3", 64'(b.out_tag), 64'd3);
    tick();
    check("full.empty", 64'(b.out_val), 64'd0);
    b.out_rdy = 1'b0;

    // Counter saturation.
    force dut.illegal_cnt_q = 16'hFFFF;
    #1;
    release dut.illegal_cnt_q;
    exp_cnt = 16'hFFFF;
    check("sat.preset", 64'(b.illegal_cnt), 64'hFFFF);
    one("sat", IMM_ILL15, 32'h1234_5678, 32'h0, 1'b1);

    // Streaming: one result per cycle, count never reaches 2.
    b.out_rdy = 1'b1;
    b.in_type = IMM_SH;
    b.in_inst = 32'h01F0D093;
    for (int k = 0; k < 20; k++) begin
      b.in_val = 1'b1;
      b.in_tag = k[3:0];
      tick();
      check("stream.val", 64'(b.out_val), 64'd1);
      check("stream.imm", 64'(b.out_imm), 64'd31);
      check("stream.tag", 64'(b.out_tag), 64'(k[3:0]));
      check("stream.rdy", 64'(b.in_rdy), 64'd1);
    end
    b.in_val = 1'b0;
    tick();
    check("stream.end", 64'(b.out_val), 64'd0);
    b.out_rdy = 1'b0;

    // Asynchronous reset mid-operation discards the queued entry.
    b.in_val = 1'b1; b.in_type = IMM_ILL7; b.in_tag = 4'd5;
    tick();
    b.in_val = 1'b0;
    check("mid.queued", 64'(b.out_val), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    exp_cnt = '0;
    check("mid.val", 64'(b.out_val), 64'd0);
    check("mid.imm_ill", 64'(b.out_illegal), 64'd0);
    check("mid.tag", 64'(b.out_tag), 64'd0);
    check("mid.cnt", 64'(b.illegal_cnt), 64'd0);
    check("mid.rdy", 64'(b.in_rdy), 64'd1);
    tick();
    reset_n = 1'b1;
    one("post_rst", IMM_I, 32'hFFF00093, 32'hFFFF_FFFF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
